// File: rtl/cla_add_seq.sv
// Sequential 32-bit adder/subtractor: one shared 16-bit carry-lookahead slice is used twice,
// first on bits 15:0 and then on bits 31:16, behind a valid/ready handshake on each side.
module cla_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ALUOp2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] result,
  output logic        cout,
  output logic        overflow,
  output logic        zero
);

  typedef enum logic [1:0] {StIdle = 2'd0, StLow = 2'd1, StHigh = 2'd2, StDone = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [31:0] a_q, b_q;
  logic        op_q;
  logic        c16_q;
  logic [31:0] result_q;
  logic        cout_q, overflow_q, zero_q;

  logic [15:0] sl_a, sl_b, sl_g, sl_p, sl_s;
  logic        sl_cin;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;
  logic [16:0] sl_c;

  // Shared 16-bit lookahead slice; operand half and carry-in are selected by state.
  always_comb begin
    sl_a   = (state_q == StHigh) ? a_q[31:16] : a_q[15:0];
    sl_b   = ((state_q == StHigh) ? b_q[31:16] : b_q[15:0]) ^ {16{op_q}};
    sl_cin = (state_q == StHigh) ? c16_q : op_q;
    sl_g   = sl_a & sl_b;
    sl_p   = sl_a | sl_b;
    for (int k = 0; k < 4; k++) begin
      grp_p[k] = &sl_p[4*k +: 4];
      grp_g[k] = sl_g[4*k+3]
               | (sl_p[4*k+3] & sl_g[4*k+2])
               | (sl_p[4*k+3] & sl_p[4*k+2] & sl_g[4*k+1])
               | (sl_p[4*k+3] & sl_p[4*k+2] & sl_p[4*k+1] & sl_g[4*k]);
    end
    // Group carries are flattened so none waits on the previous group's carry.
    grp_c[0] = sl_cin;
    grp_c[1] = grp_g[0] | (grp_p[0] & sl_cin);
    grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & sl_cin);
    grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[2] & grp_p[1] & grp_p[0] & sl_cin);
    grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
             | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & sl_cin);
    sl_c = '0;
    for (int i = 0; i < 16; i++) begin
      if (i % 4 == 0) sl_c[i] = grp_c[i/4];
      else            sl_c[i] = sl_g[i-1] | (sl_p[i-1] & sl_c[i-1]);
    end
    sl_c[16] = grp_c[4];
    sl_s     = sl_a ^ sl_b ^ sl_c[15:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = StLow;
      StLow:  state_d = StHigh;
      StHigh: state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == StIdle);
    out_valid = (state_q == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= 1'b0;
      c16_q      <= 1'b0;
      result_q   <= '0;
      cout_q     <= 1'b0;
      overflow_q <= 1'b0;
      zero_q     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q  <= a;
            b_q  <= b;
            op_q <= ALUOp2;
          end
        end
        StLow: begin
          result_q[15:0] <= sl_s;
          c16_q          <= sl_c[16];
        end
        StHigh: begin
          result_q[31:16] <= sl_s;
          cout_q          <= sl_c[16];
          overflow_q      <= sl_c[15] ^ sl_c[16];
          zero_q          <= ~|{sl_s, result_q[15:0]};
        end
        default: ;
      endcase
    end
  end

  assign result   = result_q;
  assign cout     = cout_q;
  assign overflow = overflow_q;
  assign zero     = zero_q;

endmodule

// File: tb/tb_cla_add_seq.sv
// Randomised bench for cla_add_seq: a signed/unsigned arithmetic model is checked on every DONE
// cycle, plus directed literal cases, stall, hold and asynchronous-reset scenarios.
module tb_cla_add_seq;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a, b;
  logic        ALUOp2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        cout, overflow, zero;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] exp_result;
  logic        exp_cout, exp_overflow, exp_zero;

  always #5 clk = ~clk;

  cla_add_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .ALUOp2    (ALUOp2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .cout      (cout),
    .overflow  (overflow),
    .zero      (zero)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Arithmetic reference: plain integer add/sub, signed range test for overflow.
  task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic mop);
    longint sa, sb, sr;
    sa = longint'($signed(ma));
    sb = longint'($signed(mb));
    sr = mop ? (sa - sb) : (sa + sb);
    exp_result   = mop ? (ma - mb) : (ma + mb);
    exp_cout     = mop ? (ma >= mb) : ((longint'(ma) + longint'(mb)) >= 64'sh1_0000_0000);
    exp_overflow = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
    exp_zero     = (exp_result == 32'h0);
  endtask

  // Single compare process: whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n && out_valid) begin
      check("result", result, exp_result);
      check("cout", {31'b0, cout}, {31'b0, exp_cout});
      check("overflow", {31'b0, overflow}, {31'b0, exp_overflow});
      check("zero", {31'b0, zero}, {31'b0, exp_zero});
    end
  end

  // Issue one operation; optionally stall the output and drive new operands while stalled.
  task automatic run_op(input logic [31:0] ta, input logic [31:0] tb, input logic top,
                        input int stall, input bit hammer, input bit chk_lat);
    int cnt;
    @(negedge clk);
    if (!in_ready) begin
      n_checks++;
      n_errors++;
      $display("FAIL in_ready_idle: got 0, expected 1 at %0t", $time);
    end
    model(ta, tb, top);
    a = ta; b = tb; ALUOp2 = top; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; ALUOp2 = 1'($urandom);
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    if (!out_valid) begin
      n_checks++;
      n_errors++;
      $display("FAIL out_valid_timeout: got 0, expected 1 within 10 cycles at %0t", $time);
      return;
    end
    if (chk_lat) check("latency", 32'(cnt), 32'd3);
    for (int i = 0; i < stall; i++) begin
      if (hammer) begin
        in_valid = 1'b1; a = $urandom; b = $urandom; ALUOp2 = 1'($urandom);
      end
      @(negedge clk);
      if (hammer) check("in_ready_done", {31'b0, in_ready}, 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("out_valid_drop", {31'b0, out_valid}, 32'd0);
    n_checks++;
    if (!in_ready) begin
      n_errors++;
      $display("FAIL idle_after_done: in_ready got 0, expected 1 at %0t", $time);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 9))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h7FFF_FFFF;
      4:       return 32'h0000_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; ALUOp2 = 1'b0;
    exp_result = '0; exp_cout = 1'b0; exp_overflow = 1'b0; exp_zero = 1'b0;
    rst_n = 1'b0;
    #23;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_result", result, 32'h0);
    check("rst_flags", {29'b0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Directed literal cases; outputs are held in IDLE, so they are read after completion.
    run_op(32'h0000_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1);
    check("add_carry16_res", result, 32'h0001_0000);
    check("add_carry16_flags", {29'b0, cout, overflow, zero}, 32'b000);
    run_op(32'h0000_0005, 32'h0000_0005, 1'b1, 1, 1'b0, 1'b1);
    check("sub_equal_res", result, 32'h0);
    check("sub_equal_flags", {29'b0, cout, overflow, zero}, 32'b101);
    run_op(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1);
    check("add_ovf_res", result, 32'h8000_0000);
    check("add_ovf_flags", {29'b0, cout, overflow, zero}, 32'b010);
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 0, 1'b0, 1'b1);
    check("add_wrap_res", result, 32'h0);
    check("add_wrap_flags", {29'b0, cout, overflow, zero}, 32'b101);
    run_op(32'h0000_0003, 32'h0000_0007, 1'b1, 0, 1'b0, 1'b1);
    check("sub_borrow_res", result, 32'hFFFF_FFFC);
    check("sub_borrow_flags", {29'b0, cout, overflow, zero}, 32'b000);

    // Long stall with new operands hammering the input; the next op must still be accepted.
    run_op(32'h1234_0000, 32'h0000_5678, 1'b0, 5, 1'b1, 1'b1);
    check("stall_res", result, 32'h1234_5678);
    run_op(32'h0000_0010, 32'h0000_0001, 1'b1, 0, 1'b0, 1'b1);
    check("after_stall_res", result, 32'h0000_000F);

    // Asynchronous reset in the middle of the HIGH pass.
    @(negedge clk);
    a = 32'h1234_5678; b = 32'h0000_0001; ALUOp2 = 1'b1; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_result", result, 32'h0);
    check("mid_rst_flags", {29'b0, cout, overflow, zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd2, 32'd3, 1'b0, 0, 1'b0, 1'b1);
    check("post_rst_add", result, 32'd5);

    // Random regression.
    for (int n = 0; n < 10000; n++) begin
      int st;
      st = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
      run_op(pick(), pick(), 1'($urandom), st, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
